// File: rtl/multi_pulse_pkg.sv
// multi_pulse_pkg: shared state type, counter sizing helpers and defaults for the button front end
package multi_pulse_pkg;
  typedef enum logic [1:0] {IDLE, HELD, REPEAT} ch_state_t;
  localparam int DEF_N_CH          = 5;
  localparam int DEF_DEB_CYCLES    = 100000;
  localparam int DEF_REPEAT_DELAY  = 50000000;
  localparam int DEF_REPEAT_PERIOD = 10000000;
  localparam int DEF_LONG_CYCLES   = 100000000;
  function automatic int cnt_w(input int max_val);
    return $clog2(max_val) + 1;
  endfunction
  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction
endpackage

// File: rtl/pulse_channel.sv
// pulse_channel: one button channel - synchroniser, debouncer, press/repeat/long/release event FSM
module pulse_channel
  import multi_pulse_pkg::*;
#(
  parameter int DEB_CYCLES    = DEF_DEB_CYCLES,
  parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD,
  parameter int LONG_CYCLES   = DEF_LONG_CYCLES
) (
  input  logic CLOCK,
  input  logic RESET,
  input  logic PB,
  input  logic REPEAT_EN,
  output logic LEVEL,
  output logic PRESS_PULSE,
  output logic LONG_PULSE,
  output logic RELEASE_PULSE
);
  localparam int HOLD_MAX = max2(REPEAT_DELAY, LONG_CYCLES);
  localparam int DEB_W    = cnt_w(DEB_CYCLES);
  localparam int HOLD_W   = cnt_w(HOLD_MAX);
  localparam int PER_W    = cnt_w(REPEAT_PERIOD);
  logic s1, s2;
  logic [DEB_W-1:0] deb_cnt;
  logic [HOLD_W-1:0] hold_cnt, hold_n;
  logic [PER_W-1:0] per_cnt, per_n;
  ch_state_t state, state_n;
  logic rep_off, rep_off_n;
  logic press_n, long_n, rel_n;
  logic deb_hit, rise, fall, rep_hit, long_hit, per_hit;
  assign deb_hit  = (s2 != LEVEL) && (deb_cnt == DEB_W'(DEB_CYCLES - 1));
  assign rise     = deb_hit && s2;
  assign fall     = deb_hit && !s2;
  assign rep_hit  = hold_cnt == HOLD_W'(REPEAT_DELAY - 1);
  assign long_hit = hold_cnt == HOLD_W'(LONG_CYCLES - 1);
  assign per_hit  = per_cnt == PER_W'(REPEAT_PERIOD - 1);
  // synchronise the raw button and accept a new level after a full run of mismatching cycles
  always_ff @(posedge CLOCK or posedge RESET)
    if (RESET) begin
      s1      <= 1'b0;
      s2      <= 1'b0;
      deb_cnt <= '0;
      LEVEL   <= 1'b0;
    end else begin
      s1      <= PB;
      s2      <= s1;
      deb_cnt <= (s2 == LEVEL || deb_hit) ? '0 : deb_cnt + 1'b1;
      if (deb_hit) LEVEL <= s2;
    end
  // state, hold/period counters and registered event pulses
  always_ff @(posedge CLOCK or posedge RESET)
    if (RESET) begin
      state         <= IDLE;
      hold_cnt      <= '0;
      per_cnt       <= '0;
      rep_off       <= 1'b0;
      PRESS_PULSE   <= 1'b0;
      LONG_PULSE    <= 1'b0;
      RELEASE_PULSE <= 1'b0;
    end else begin
      state         <= state_n;
      hold_cnt      <= hold_n;
      per_cnt       <= per_n;
      rep_off       <= rep_off_n;
      PRESS_PULSE   <= press_n;
      LONG_PULSE    <= long_n;
      RELEASE_PULSE <= rel_n;
    end
  // next state and next pulses; the hold counter saturates so the long pulse fires once per press
  always_comb begin
    state_n   = state;
    hold_n    = hold_cnt;
    per_n     = per_cnt;
    rep_off_n = rep_off;
    press_n   = 1'b0;
    long_n    = 1'b0;
    rel_n     = 1'b0;
    case (state)
      IDLE:
        if (rise) begin
          state_n = HELD;
          press_n = 1'b1;
          hold_n  = '0;
        end
      HELD:
        if (fall) begin
          state_n = IDLE;
          rel_n   = 1'b1;
        end else begin
          hold_n = (hold_cnt == HOLD_W'(HOLD_MAX)) ? hold_cnt : hold_cnt + 1'b1;
          long_n = long_hit;
          if (rep_hit && REPEAT_EN) begin
            state_n   = REPEAT;
            press_n   = 1'b1;
            per_n     = '0;
            rep_off_n = 1'b0;
          end
        end
      REPEAT:
        if (fall) begin
          state_n = IDLE;
          rel_n   = 1'b1;
        end else begin
          hold_n    = (hold_cnt == HOLD_W'(HOLD_MAX)) ? hold_cnt : hold_cnt + 1'b1;
          long_n    = long_hit;
          per_n     = per_hit ? '0 : per_cnt + 1'b1;
          rep_off_n = rep_off || !REPEAT_EN;
          press_n   = per_hit && REPEAT_EN && !rep_off;
        end
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: rtl/multi_pulse_generator.sv
// multi_pulse_generator: N independent debounced push-button channels producing clean event pulses
module multi_pulse_generator
  import multi_pulse_pkg::*;
#(
  parameter int N_CH          = DEF_N_CH,
  parameter int DEB_CYCLES    = DEF_DEB_CYCLES,
  parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD,
  parameter int LONG_CYCLES   = DEF_LONG_CYCLES
) (
  input  logic            CLOCK,
  input  logic            RESET,
  input  logic [N_CH-1:0] PB,
  input  logic [N_CH-1:0] REPEAT_EN,
  output logic [N_CH-1:0] LEVEL,
  output logic [N_CH-1:0] PRESS_PULSE,
  output logic [N_CH-1:0] LONG_PULSE,
  output logic [N_CH-1:0] RELEASE_PULSE
);
  genvar i;
  for (i = 0; i < N_CH; i++) begin : g_ch
    pulse_channel #(
      .DEB_CYCLES   (DEB_CYCLES),
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD),
      .LONG_CYCLES  (LONG_CYCLES)
    ) u_ch (
      .CLOCK        (CLOCK),
      .RESET        (RESET),
      .PB           (PB[i]),
      .REPEAT_EN    (REPEAT_EN[i]),
      .LEVEL        (LEVEL[i]),
      .PRESS_PULSE  (PRESS_PULSE[i]),
      .LONG_PULSE   (LONG_PULSE[i]),
      .RELEASE_PULSE(RELEASE_PULSE[i])
    );
  end
endmodule

// File: tb/tb_multi_pulse_generator.sv
// tb_multi_pulse_generator: scoreboard bench for the button front end with short debounce/repeat timings
module tb_multi_pulse_generator;
  logic       CLOCK = 1'b0;
  logic       RESET = 1'b0;
  logic [1:0] PB = 2'b00;
  logic [1:0] REPEAT_EN = 2'b00;
  logic [1:0] LEVEL, PRESS_PULSE, LONG_PULSE, RELEASE_PULSE;
  int cyc = 0;
  int vectors = 0;
  int errors = 0;
  int c0, p;
  typedef struct {
    int cyc;
    logic [1:0] press;
    logic [1:0] lng;
    logic [1:0] rel;
  } ev_t;
  ev_t sb[$];

  multi_pulse_generator #(
    .N_CH(2), .DEB_CYCLES(4), .REPEAT_DELAY(8), .REPEAT_PERIOD(3), .LONG_CYCLES(12)
  ) dut (
    .CLOCK(CLOCK), .RESET(RESET), .PB(PB), .REPEAT_EN(REPEAT_EN),
    .LEVEL(LEVEL), .PRESS_PULSE(PRESS_PULSE), .LONG_PULSE(LONG_PULSE), .RELEASE_PULSE(RELEASE_PULSE)
  );

  always #5 CLOCK = ~CLOCK;
  always @(posedge CLOCK) cyc <= cyc + 1;

  task automatic exp_ev(input int c, input logic [1:0] pr, input logic [1:0] lg, input logic [1:0] rl);
    ev_t e;
    e.cyc = c;
    e.press = pr;
    e.lng = lg;
    e.rel = rl;
    sb.push_back(e);
  endtask

  task automatic chk(input string nm, input logic [1:0] got, input logic [1:0] want);
    vectors++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s @%0d: got %b, required %b", nm, cyc, got, want);
    end
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge CLOCK);
  endtask

  always @(negedge CLOCK) begin
    ev_t e;
    if ((PRESS_PULSE | LONG_PULSE | RELEASE_PULSE) != 2'b00) begin
      vectors++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event @%0d: got press=%b long=%b rel=%b, required no event",
                 cyc, PRESS_PULSE, LONG_PULSE, RELEASE_PULSE);
      end else begin
        e = sb.pop_front();
        if (e.cyc != cyc || e.press !== PRESS_PULSE || e.lng !== LONG_PULSE || e.rel !== RELEASE_PULSE) begin
          errors++;
          $display("FAIL event: got @%0d press=%b long=%b rel=%b, required @%0d press=%b long=%b rel=%b",
                   cyc, PRESS_PULSE, LONG_PULSE, RELEASE_PULSE, e.cyc, e.press, e.lng, e.rel);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    #1 RESET = 1'b1;
    #1 chk("reset_level", LEVEL, 2'b00);
    chk("reset_pulses", PRESS_PULSE | LONG_PULSE | RELEASE_PULSE, 2'b00);
    wait_n(3);
    RESET = 1'b0;
    wait_n(2);
    // clean press on channel 0, no repeat
    c0 = cyc;
    PB[0] = 1'b1;
    exp_ev(c0 + 6, 2'b00 | 2'b01, 2'b00, 2'b00);
    exp_ev(c0 + 18, 2'b00, 2'b01, 2'b00);
    exp_ev(c0 + 26, 2'b00, 2'b00, 2'b01);
    wait_n(5);
    chk("clean_level_before", LEVEL, 2'b00);
    wait_n(1);
    chk("clean_level_after", LEVEL, 2'b01);
    wait_n(14);
    PB[0] = 1'b0;
    wait_n(5);
    chk("clean_release_before", LEVEL, 2'b01);
    wait_n(1);
    chk("clean_release_after", LEVEL, 2'b00);
    wait_n(4);
    // bounce 1,0,1,1,0 then steady 1
    c0 = cyc;
    PB[0] = 1'b1;
    wait_n(1); PB[0] = 1'b0;
    wait_n(1); PB[0] = 1'b1;
    wait_n(1); PB[0] = 1'b1;
    wait_n(1); PB[0] = 1'b0;
    wait_n(1); PB[0] = 1'b1;
    exp_ev(c0 + 11, 2'b01, 2'b00, 2'b00);
    exp_ev(c0 + 23, 2'b00, 2'b01, 2'b00);
    exp_ev(c0 + 31, 2'b00, 2'b00, 2'b01);
    wait_n(5);
    chk("bounce_level_before", LEVEL, 2'b00);
    wait_n(1);
    chk("bounce_level_after", LEVEL, 2'b01);
    wait_n(14);
    PB[0] = 1'b0;
    wait_n(10);
    // auto-repeat and long press on channel 0
    REPEAT_EN = 2'b01;
    c0 = cyc;
    p = c0 + 6;
    PB[0] = 1'b1;
    exp_ev(p, 2'b01, 2'b00, 2'b00);
    exp_ev(p + 8, 2'b01, 2'b00, 2'b00);
    exp_ev(p + 11, 2'b01, 2'b00, 2'b00);
    exp_ev(p + 12, 2'b00, 2'b01, 2'b00);
    exp_ev(p + 14, 2'b01, 2'b00, 2'b00);
    exp_ev(p + 17, 2'b01, 2'b00, 2'b00);
    exp_ev(p + 20, 2'b01, 2'b00, 2'b00);
    exp_ev(p + 23, 2'b00, 2'b00, 2'b01);
    wait_n(23);
    PB[0] = 1'b0;
    wait_n(10);
    REPEAT_EN = 2'b00;
    // repeat enable dropped mid-repeat on channel 1
    REPEAT_EN = 2'b10;
    c0 = cyc;
    p = c0 + 6;
    PB[1] = 1'b1;
    exp_ev(p, 2'b10, 2'b00, 2'b00);
    exp_ev(p + 8, 2'b10, 2'b00, 2'b00);
    exp_ev(p + 11, 2'b10, 2'b00, 2'b00);
    exp_ev(p + 12, 2'b00, 2'b10, 2'b00);
    exp_ev(p + 26, 2'b00, 2'b00, 2'b10);
    wait_n(18);
    REPEAT_EN = 2'b00;
    wait_n(8);
    PB[1] = 1'b0;
    wait_n(10);
    // reset while held, button still down afterwards
    c0 = cyc;
    PB[0] = 1'b1;
    exp_ev(c0 + 6, 2'b01, 2'b00, 2'b00);
    wait_n(8);
    chk("hold_level_pre_reset", LEVEL, 2'b01);
    #2 RESET = 1'b1;
    #1 chk("midreset_level", LEVEL, 2'b00);
    chk("midreset_pulses", PRESS_PULSE | LONG_PULSE | RELEASE_PULSE, 2'b00);
    wait_n(2);
    RESET = 1'b0;
    c0 = cyc;
    exp_ev(c0 + 6, 2'b01, 2'b00, 2'b00);
    exp_ev(c0 + 18, 2'b00, 2'b01, 2'b00);
    exp_ev(c0 + 26, 2'b00, 2'b00, 2'b01);
    wait_n(5);
    chk("postreset_level_before", LEVEL, 2'b00);
    wait_n(1);
    chk("postreset_level_after", LEVEL, 2'b01);
    wait_n(14);
    PB[0] = 1'b0;
    wait_n(10);
    // simultaneous press on both channels
    c0 = cyc;
    PB = 2'b11;
    exp_ev(c0 + 6, 2'b11, 2'b00, 2'b00);
    exp_ev(c0 + 18, 2'b00, 2'b11, 2'b00);
    exp_ev(c0 + 26, 2'b00, 2'b00, 2'b11);
    wait_n(6);
    chk("both_level", LEVEL, 2'b11);
    wait_n(14);
    PB = 2'b00;
    wait_n(10);
    chk("idle_level_end", LEVEL, 2'b00);
    vectors++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL missing_events: got %0d events outstanding, required 0 (next due @%0d)", sb.size(), sb[0].cyc);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/multi_pulse_generator.md
# multi_pulse_generator

Parametrised N-channel push-button front end that turns raw, asynchronous, bouncy button levels into clean single-cycle event pulses. Per channel it synchronises, debounces, and emits a press pulse, optional auto-repeat pulses while held, a one-shot long-press pulse, and a release pulse. It sits between the board pushbuttons and every control FSM that consumes button events, such as menu, trigger and timebase controls.

## Interface
- N_CH, default 5: number of independent button channels (≥1).
- DEB_CYCLES, default 100000: consecutive stable cycles required to accept a level change (≥1).
- REPEAT_DELAY, default 50000000: cycles from accepted press to first auto-repeat pulse (≥1).
- REPEAT_PERIOD, default 10000000: cycles between subsequent auto-repeat pulses (≥1).
- LONG_CYCLES, default 100000000: cycles from accepted press to the long-press pulse (≥1).
- CLOCK  input  1  system clock; all state updates on its rising edge.
- RESET  input  1  asynchronous, active-high reset.
- PB  input  N_CH  raw button levels, asynchronous to CLOCK, active-high.
- REPEAT_EN  input  N_CH  per-channel auto-repeat enable; sampled every cycle.
- LEVEL  output  N_CH  debounced button level.
- PRESS_PULSE  output  N_CH  one-cycle pulse on each accepted press and on each auto-repeat.
- LONG_PULSE  output  N_CH  one-cycle pulse when a press has been held LONG_CYCLES.
- RELEASE_PULSE  output  N_CH  one-cycle pulse on each accepted release.

## Operation
- Channels are fully independent. Simultaneous events on different channels are all reported in the same cycle.
- Synchroniser: two flops per channel, PB → s1 → s2. Only s2 is used downstream.
- Debounce: a counter runs while s2 ≠ LEVEL and clears to 0 whenever s2 = LEVEL. The level is accepted when the counter has seen DEB_CYCLES consecutive mismatching cycles. Any bounce back restarts the count.
- Per-channel FSM with states IDLE, HELD and REPEAT:
  - IDLE → HELD on an accepted press: LEVEL goes to 1, PRESS_PULSE fires, and the hold counter clears.
  - In HELD, the hold counter increments every cycle and saturates at max(REPEAT_DELAY, LONG_CYCLES).
  - HELD → REPEAT when the hold counter reaches REPEAT_DELAY and REPEAT_EN=1: PRESS_PULSE fires and the period counter clears.
  - In REPEAT, PRESS_PULSE fires each time the period counter reaches REPEAT_PERIOD, then the counter clears. The hold counter keeps running.
  - HELD or REPEAT → IDLE on an accepted release: LEVEL goes to 0 and RELEASE_PULSE fires.
  - REPEAT_EN falling while in REPEAT: stay in REPEAT with no further repeat pulses until release.
- LONG_PULSE fires once per press, in the cycle where the hold counter reaches LONG_CYCLES, from either HELD or REPEAT.
- If LONG_PULSE and PRESS_PULSE coincide, both are asserted.
- Counter widths are $clog2 of the largest value each counter must reach, plus 1. Counters never wrap.
- Reset (asynchronous):
  - All outputs go to 0; LEVEL=0; synchroniser flops and all counters go to 0; FSM goes to IDLE.
  - This applies mid-press and mid-debounce as well.
  - A button still held when RESET deasserts is treated as a new press and debounced normally.

## Timing
- Let k be the first rising edge at which PB[i]=1 and stays 1. s2=1 from edge k+1. LEVEL=1 and PRESS_PULSE=1 from edge k+1+DEB_CYCLES, with PRESS_PULSE lasting exactly one cycle.
- Release has the same latency for LEVEL=0 and RELEASE_PULSE.
- With press accepted at edge p:
  - First repeat pulse at edge p+REPEAT_DELAY.
  - Subsequent repeat pulses at p+REPEAT_DELAY+m·REPEAT_PERIOD.
  - LONG_PULSE at edge p+LONG_CYCLES.
- Every pulse output is registered, high for exactly one CLOCK cycle, and never high in two consecutive cycles, except when REPEAT_PERIOD=1.
- No combinational path from inputs to outputs.

## Structure
- Package multi_pulse_pkg holds:
  - the channel state enum (IDLE, HELD, REPEAT);
  - a width helper function for counter sizing;
  - default parameter constants.
- Sub-module pulse_channel implements one channel (synchroniser, debounce, FSM, counters). The top level instantiates it N_CH times in a generate loop and concatenates the outputs.

## Test plan
- Clean press, with N_CH=2, DEB_CYCLES=4, REPEAT_EN=0: PB[0] rises before edge 10 and is held 20 cycles.
  - LEVEL[0] and PRESS_PULSE[0] rise at edge 15; PRESS_PULSE[0] lasts one cycle.
  - RELEASE_PULSE[0] fires 5 edges after PB[0] falls.
  - Channel 1 stays all-zero throughout.
- Bounce rejection: PB toggles 1,0,1,1,0 at 1-cycle spacing, then holds 1.
  - No pulse during the toggling.
  - A single PRESS_PULSE fires exactly 5 edges after the final rise.
- Auto-repeat and long press, with REPEAT_DELAY=8, REPEAT_PERIOD=3, LONG_CYCLES=12, REPEAT_EN=1, press accepted at edge p:
  - PRESS_PULSE at p, p+8, p+11, p+14, …
  - LONG_PULSE only at p+12.
  - Repeat pulses stop at release.
- REPEAT_EN dropped mid-repeat: no PRESS_PULSE after the drop; RELEASE_PULSE still occurs on release.
- Reset mid-hold: assert RESET while LEVEL=1.
  - All outputs are 0 immediately, without waiting for a clock edge.
  - With PB still held after deassertion, PRESS_PULSE fires DEB_CYCLES+1 edges later.
- Simultaneous press on all N_CH channels: identical, same-cycle PRESS_PULSE on every bit.
